// File: rtl/axilite_user_arbiter_if.sv
// axilite_user_arbiter_if: requester-side and AXI-lite master user-port signals of the arbiter
interface axilite_user_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int LAT_W   = 16
);
   localparam int STRB_W = DATA_W / 8;
   localparam int ID_W   = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0]        req_valid, req_ready, req_w_r, rsp_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ*STRB_W-1:0] req_strb;
   logic [DATA_W-1:0]         rsp_data;
   logic [1:0]                rsp_status;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;
   logic [LAT_W-1:0]          last_latency;
   logic                      user_start, user_w_r;
   logic [ADDR_W-1:0]         user_addr_in;
   logic [DATA_W-1:0]         user_data_in;
   logic [STRB_W-1:0]         user_data_strb;
   logic                      user_free;
   logic [1:0]                user_status;
   logic [DATA_W-1:0]         user_data_out;
   logic                      user_data_out_en;
   // master: the arbiter's view; slave: requesters plus the AXI-lite master
   modport master (
      input  req_valid, req_w_r, req_addr, req_data, req_strb,
      input  user_free, user_status, user_data_out, user_data_out_en,
      output req_ready, rsp_valid, rsp_data, rsp_status, grant_id, busy, last_latency,
      output user_start, user_w_r, user_addr_in, user_data_in, user_data_strb
   );
   modport slave (
      output req_valid, req_w_r, req_addr, req_data, req_strb,
      output user_free, user_status, user_data_out, user_data_out_en,
      input  req_ready, rsp_valid, rsp_data, rsp_status, grant_id, busy, last_latency,
      input  user_start, user_w_r, user_addr_in, user_data_in, user_data_strb
   );
endinterface

// File: rtl/axilite_user_arbiter.sv
// axilite_user_arbiter: round-robin sharing of one AXI-lite master user port among NUM_REQ requesters
module axilite_user_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int LAT_W   = 16
) (
   input logic                   aclk,
   input logic                   areset,
   axilite_user_arbiter_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int ID_W   = $clog2(NUM_REQ);
   localparam logic [2:0] IDLE = 3'd0, START = 3'd1, WAIT_BUSY = 3'd2, WAIT_DONE = 3'd3, RESP = 3'd4;
   logic [2:0]       state;
   logic [ID_W-1:0]  last_grant, win_hi, win_lo, win;
   logic             hi_hit, accept, rd_done, wr_done;
   logic [LAT_W-1:0] lat;
   // descending scan leaves the lowest requester above last_grant, else the lowest at/below it
   always_comb begin
      hi_hit = 1'b0;
      win_hi = '0;
      win_lo = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i] && ID_W'(i) > last_grant) begin
            hi_hit = 1'b1;
            win_hi = ID_W'(i);
         end
         if (bus.req_valid[i] && ID_W'(i) <= last_grant) win_lo = ID_W'(i);
      end
   end
   assign win           = hi_hit ? win_hi : win_lo;
   assign accept        = !areset && state == IDLE && bus.user_free && |bus.req_valid;
   assign bus.req_ready = accept ? NUM_REQ'(1) << win : '0;
   assign bus.busy       = state != IDLE;
   assign bus.user_start = state == START;
   assign rd_done = bus.user_w_r && bus.user_data_out_en && (state == WAIT_BUSY || state == WAIT_DONE);
   assign wr_done = !bus.user_w_r && bus.user_free && state == WAIT_DONE;
   always_ff @(posedge aclk) begin
      bus.rsp_valid <= '0;
      if (areset) begin
         state               <= IDLE;
         last_grant          <= ID_W'(NUM_REQ - 1);
         lat                 <= '0;
         bus.grant_id        <= '0;
         bus.user_w_r        <= 1'b0;
         bus.user_addr_in    <= '0;
         bus.user_data_in    <= '0;
         bus.user_data_strb  <= '0;
         bus.rsp_data        <= '0;
         bus.rsp_status      <= '0;
         bus.last_latency    <= '0;
      end else begin
         if (accept) begin
            state              <= START;
            bus.grant_id       <= win;
            bus.user_w_r       <= bus.req_w_r[win];
            bus.user_addr_in   <= bus.req_addr[win*ADDR_W +: ADDR_W];
            bus.user_data_in   <= bus.req_w_r[win] ? '0 : bus.req_data[win*DATA_W +: DATA_W];
            bus.user_data_strb <= bus.req_w_r[win] ? '0 : bus.req_strb[win*STRB_W +: STRB_W];
         end
         if (state == START) begin
            state <= WAIT_BUSY;
            lat   <= '0;
         end
         if (state == WAIT_BUSY || state == WAIT_DONE) begin
            if (lat != '1) lat <= lat + 1'b1;
            if (state == WAIT_BUSY && !bus.user_free) state <= WAIT_DONE;
            if (rd_done || wr_done) begin
               state          <= RESP;
               bus.rsp_valid  <= NUM_REQ'(1) << bus.grant_id;
               bus.rsp_data   <= rd_done ? bus.user_data_out : '0;
               bus.rsp_status <= bus.user_status;
            end
         end
         if (state == RESP) begin
            state            <= IDLE;
            last_grant       <= bus.grant_id;
            bus.last_latency <= lat;
         end
      end
   end
endmodule

// File: tb/tb_axilite_user_arbiter.sv
// tb_axilite_user_arbiter: directed bench with a scoreboard of expected responses and a behavioural AXI-lite master
module tb_axilite_user_arbiter;
   typedef struct {
      int          id;
      logic [63:0] data;
      logic [1:0]  st;
      logic        rd;
   } exp_t;
   logic aclk = 1'b0, areset = 1'b1;
   logic m_free = 1'b1, hold = 1'b0;
   int nchk = 0, nfail = 0, cyc = 0, n_start = 0, n_rsp = 0, n_acc = 0, en_cyc = -10, rd_delay = 3;
   logic [3:0] rdy_seen;
   logic [63:0] mem [logic [31:0]];
   exp_t sb [$];
   axilite_user_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .LAT_W(16)) bus ();
   axilite_user_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(64), .LAT_W(16)) dut (
      .aclk(aclk), .areset(areset), .bus(bus.master)
   );
   assign bus.user_free = m_free & ~hold;
   always #5 aclk = ~aclk;
   initial forever begin
      @(posedge aclk);
      cyc++;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask
   function automatic exp_t mk(input int id, input logic [63:0] d, input logic [1:0] st, input logic rd);
      exp_t e;
      e.id = id; e.data = d; e.st = st; e.rd = rd;
      return e;
   endfunction
   task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
      bus.req_w_r[i] = w;
      bus.req_addr[i*32 +: 32] = a;
      bus.req_data[i*64 +: 64] = d;
      bus.req_strb[i*8 +: 8] = s;
      bus.req_valid[i] = 1'b1;
   endtask
   task automatic wait_grant(output int id);
      int t;
      id = -1;
      t = 0;
      while (id < 0 && t < 200) begin
         @(negedge aclk);
         t++;
         rdy_seen = bus.req_ready;
         for (int i = 0; i < 4; i++) if (bus.req_ready[i]) id = i;
      end
      chk("grant_seen", id >= 0, 1);
      @(posedge aclk);
      #1;
   endtask
   task automatic drain(input int bound);
      int t = 0;
      while (sb.size() > 0 && t < bound) begin
         @(posedge aclk);
         t++;
      end
      repeat (2) @(posedge aclk);
      #1;
      chk("drain", sb.size(), 0);
   endtask
   task automatic chk_rst(input string t);
      chk({t, "_busy"}, bus.busy, 0);
      chk({t, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({t, "_rsp_data"}, bus.rsp_data, 0);
      chk({t, "_rsp_status"}, bus.rsp_status, 0);
      chk({t, "_user_start"}, bus.user_start, 0);
      chk({t, "_user_w_r"}, bus.user_w_r, 0);
      chk({t, "_user_addr"}, bus.user_addr_in, 0);
      chk({t, "_user_data"}, bus.user_data_in, 0);
      chk({t, "_user_strb"}, bus.user_data_strb, 0);
      chk({t, "_grant_id"}, bus.grant_id, 0);
      chk({t, "_last_latency"}, bus.last_latency, 0);
      chk({t, "_req_ready"}, bus.req_ready, 0);
   endtask
   // behavioural AXI-lite master: byte-strobed memory, write status 01, read status 10
   initial begin
      logic w;
      logic [31:0] a;
      logic [63:0] d, old;
      logic [7:0] s;
      bus.user_data_out_en = 1'b0;
      bus.user_data_out = '0;
      bus.user_status = '0;
      forever begin
         @(negedge aclk);
         if (bus.user_start === 1'b1) begin
            w = bus.user_w_r; a = bus.user_addr_in; d = bus.user_data_in; s = bus.user_data_strb;
            @(posedge aclk);
            #1 m_free = 1'b0;
            if (w) begin
               repeat (rd_delay) @(posedge aclk);
               #1;
               bus.user_data_out = mem.exists(a) ? mem[a] : '0;
               bus.user_status = 2'b10;
               bus.user_data_out_en = 1'b1;
               @(posedge aclk);
               #1;
               bus.user_data_out_en = 1'b0;
               m_free = 1'b1;
            end else begin
               repeat (2) @(posedge aclk);
               #1;
               old = mem.exists(a) ? mem[a] : '0;
               for (int b = 0; b < 8; b++) if (s[b]) old[b*8 +: 8] = d[b*8 +: 8];
               mem[a] = old;
               bus.user_status = 2'b01;
               m_free = 1'b1;
            end
         end
      end
   end
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         if (bus.user_start) n_start++;
         if (|bus.req_ready) n_acc++;
         if (bus.user_data_out_en) en_cyc = cyc;
         if (|bus.rsp_valid) begin
            n_rsp++;
            chk("rsp_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("rsp_valid", bus.rsp_valid, 64'(1) << e.id);
               chk("rsp_data", bus.rsp_data, e.data);
               chk("rsp_status", bus.rsp_status, e.st);
               if (e.rd) chk("rsp_after_en", cyc, en_cyc + 1);
            end
         end
      end
   end
   initial begin
      int g, a0, s0, r0;
      bus.req_valid = '0; bus.req_w_r = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_strb = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk_rst("init");
      areset = 1'b0;
      s0 = n_start; r0 = n_rsp;
      sb.push_back(mk(0, 64'h0, 2'b01, 1'b0));
      set_cmd(0, 1'b0, 32'h1000_0000, 64'hF8F4_F2F1, 8'hFF);
      wait_grant(g);
      bus.req_valid[0] = 1'b0;
      chk("t1_grant", g, 0);
      chk("t1_ready", rdy_seen, 4'b0001);
      chk("t1_start", bus.user_start, 1);
      chk("t1_addr", bus.user_addr_in, 32'h1000_0000);
      chk("t1_data", bus.user_data_in, 64'hF8F4_F2F1);
      chk("t1_strb", bus.user_data_strb, 8'hFF);
      chk("t1_busy", bus.busy, 1);
      @(posedge aclk);
      #1 chk("t1_start_pulse", bus.user_start, 0);
      drain(100);
      chk("t1_starts", n_start - s0, 1);
      chk("t1_rsps", n_rsp - r0, 1);
      sb.push_back(mk(2, 64'h0000_0000_F8F4_F2F1, 2'b10, 1'b1));
      set_cmd(2, 1'b1, 32'h1000_0000, 64'hDEAD_BEEF, 8'hFF);
      wait_grant(g);
      bus.req_valid[2] = 1'b0;
      chk("t2_grant", g, 2);
      chk("t2_w_r", bus.user_w_r, 1);
      chk("t2_strb", bus.user_data_strb, 0);
      chk("t2_data_in", bus.user_data_in, 0);
      chk("t2_grant_id", bus.grant_id, 2);
      drain(100);
      chk("t2_latency", bus.last_latency, 4);
      sb.push_back(mk(3, 64'h0, 2'b01, 1'b0));
      set_cmd(3, 1'b0, 32'h2000_0018, '1, 8'hFF);
      wait_grant(g);
      bus.req_valid[3] = 1'b0;
      chk("pre_grant", g, 3);
      drain(100);
      s0 = n_start; r0 = n_rsp;
      for (int k = 0; k < 5; k++) sb.push_back(mk(k % 4, 64'h0, 2'b01, 1'b0));
      set_cmd(0, 1'b0, 32'h2000_0000, 64'h0102_0304_0506_0708, 8'h0F);
      set_cmd(1, 1'b0, 32'h2000_0008, 64'h1112_1314_1516_1718, 8'hF0);
      set_cmd(2, 1'b0, 32'h2000_0010, 64'h2122_2324_2526_2728, 8'h01);
      set_cmd(3, 1'b0, 32'h2000_0018, 64'h1111_2222_3333_4444, 8'hAA);
      for (int k = 0; k < 5; k++) begin
         wait_grant(g);
         chk("rr_order", g, k % 4);
         if (k == 0) set_cmd(0, 1'b0, 32'h2000_0020, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
         else if (g >= 0) bus.req_valid[g] = 1'b0;
      end
      bus.req_valid = '0;
      drain(300);
      chk("rr_starts", n_start - s0, 5);
      chk("rr_rsps", n_rsp - r0, 5);
      chk("rr_grant_id", bus.grant_id, 0);
      sb.push_back(mk(1, 64'h11FF_22FF_33FF_44FF, 2'b10, 1'b1));
      set_cmd(1, 1'b1, 32'h2000_0018, 64'h0, 8'h00);
      wait_grant(g);
      bus.req_valid[1] = 1'b0;
      drain(100);
      hold = 1'b1;
      a0 = n_acc; s0 = n_start;
      set_cmd(1, 1'b0, 32'h3000_0000, 64'h55, 8'h01);
      repeat (6) @(posedge aclk);
      #1;
      chk("hold_ready", bus.req_ready, 0);
      chk("hold_accepts", n_acc - a0, 0);
      chk("hold_starts", n_start - s0, 0);
      sb.push_back(mk(1, 64'h0, 2'b01, 1'b0));
      hold = 1'b0;
      wait_grant(g);
      bus.req_valid[1] = 1'b0;
      chk("hold_grant", g, 1);
      chk("hold_start", bus.user_start, 1);
      drain(100);
      rd_delay = 20;
      set_cmd(3, 1'b1, 32'h1000_0000, 64'h0, 8'h00);
      wait_grant(g);
      bus.req_valid[3] = 1'b0;
      chk("rst_grant", g, 3);
      repeat (3) @(posedge aclk);
      #1 chk("rst_busy", bus.busy, 1);
      areset = 1'b1;
      @(posedge aclk);
      #1 chk_rst("midrst");
      areset = 1'b0;
      sb.push_back(mk(0, 64'h0, 2'b01, 1'b0));
      sb.push_back(mk(2, 64'h0, 2'b01, 1'b0));
      set_cmd(0, 1'b0, 32'h4000_0000, 64'h1, 8'hFF);
      set_cmd(2, 1'b0, 32'h4000_0008, 64'h2, 8'hFF);
      wait_grant(g);
      bus.req_valid[0] = 1'b0;
      chk("rst_next_grant", g, 0);
      wait_grant(g);
      bus.req_valid[2] = 1'b0;
      chk("rst_second_grant", g, 2);
      drain(300);
      rd_delay = 70000;
      sb.push_back(mk(2, 64'h0000_0000_F8F4_F2F1, 2'b10, 1'b1));
      set_cmd(2, 1'b1, 32'h1000_0000, 64'h0, 8'h00);
      wait_grant(g);
      bus.req_valid[2] = 1'b0;
      drain(80000);
      chk("sat_latency", bus.last_latency, 16'hFFFF);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/axilite_user_arbiter.md
# axilite_user_arbiter

Round-robin arbiter that shares the single AXI-lite master user port (start/free/status/data_out_en handshake) between NUM_REQ independent requesters. It sits between the requesters and the AXI-lite master, inside the design wrapper. It accepts one command at a time, sequences the master's start pulse, and tracks busy and completion. It returns read data and status to the requester that issued the command.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data width; STRB_W = DATA_W/8
- LAT_W, 16, width of latency counter
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot accept; combinational, only in IDLE
- req_w_r  in  NUM_REQ  0=write, 1=read
- req_addr  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data
- req_strb  in  NUM_REQ*STRB_W  packed write strobes
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to granted requester
- rsp_data  out  DATA_W  read data (0 for writes), valid with rsp_valid
- rsp_status  out  2  master user_status captured at completion
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- busy  out  1  high from accept until RESP cycle inclusive
- last_latency  out  LAT_W  cycles from START to completion of last command, saturating
- user_start, user_w_r, user_addr_in, user_data_in, user_data_strb  out  1/1/ADDR_W/DATA_W/STRB_W  to master
- user_free, user_status, user_data_out, user_data_out_en  in  1/2/DATA_W/1  from master

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if user_free=1 and any req_valid, the winner is the first requester with req_valid, searching from last_grant+1 upward with wrap. req_ready[winner]=1 in that same cycle. The command is latched on that edge. grant_id is updated. The state goes to START.
- START: user_start=1 for exactly this cycle. The state goes to WAIT_BUSY. The latency counter is cleared.
- WAIT_BUSY: on user_free=0, go to WAIT_DONE. For a read, user_data_out_en=1 completes directly: capture and go to RESP.
- WAIT_DONE, read: on user_data_out_en=1, capture user_data_out and user_status, then go to RESP.
- WAIT_DONE, write: on user_free=1, capture user_status, set data to 0, then go to RESP.
- RESP: rsp_valid[grant_id]=1 for one cycle. last_grant is set to grant_id. last_latency is written. The state goes to IDLE.
- user_addr_in, user_data_in, user_data_strb and user_w_r are registered. They hold the latched command from the cycle after accept until the next accept.
- For reads, user_data_strb=0 and user_data_in=0.
- Requesters hold their fields stable while req_valid=1. A requester may drop req_valid before it is granted.
- Latency counter: starts at 0 in START, increments each cycle in WAIT_BUSY/WAIT_DONE, and saturates at 2^LAT_W-1.
- Reset: from any state, the next state is IDLE. last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset values: req_ready 0, rsp_valid 0, rsp_data 0, rsp_status 0, user_start 0, user_w_r 0, user_addr_in 0, user_data_in 0, user_data_strb 0, grant_id 0, busy 0, last_latency 0.
- A reset mid-transaction drops the command with no rsp_valid.

## Timing
- Accept edge at cycle T: user_start is high in T+1 with the command already stable on the master inputs.
- Completion event sampled at edge E: rsp_valid is high in E+1. The earliest next accept is cycle E+2.
- Minimum accept-to-accept spacing is 4 cycles: START, WAIT_BUSY, RESP, IDLE.
- No accept occurs while user_free=0 in IDLE. req_ready stays 0.
- A requester whose req_valid is held continuously waits at most NUM_REQ-1 other grants.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority after the first grant.

## Test plan
- Single write, requester 0: addr 0x10000000, data 0xF8F4F2F1, strb 0xFF. Required: user_start pulses once, exactly 1 cycle after req_ready[0], with user_addr_in=0x10000000. rsp_valid[0] pulses once, rsp_data=0.
- Read back: requester 2 reads 0x10000000. Required: rsp_data=0x00000000F8F4F2F1, rsp_valid[2] the cycle after user_data_out_en, user_data_strb=0 during the read.
- All 4 requesters assert req_valid every cycle with distinct writes (strb 0x0F, 0xF0, 0x01, 0xAA). Required: grant order 0,1,2,3,0. Each rsp_valid pulses exactly once per grant, and user_start count equals rsp_valid count.
- Requester 1 asserts req_valid while master user_free=0 is forced low in IDLE. Required: req_ready stays 0 and no user_start until user_free=1.
- Assert areset during WAIT_DONE of a read. Required: the next cycle has state IDLE, all outputs at reset values, no rsp_valid. The next grant goes to requester 0 when it is requesting.
- Master delays user_data_out_en by 70000 cycles. Required: last_latency=0xFFFF, saturated, and rsp_data is still correct.
